// File: rtl/fifo_pkg.sv
// fifo_pkg: shared Gray/binary helpers and defaults for both FIFO pointer controllers
package fifo_pkg;
  localparam int FIFO_ADDR_WIDTH = 4;
  localparam int MAX_WIDTH = 32;
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_to_bin.sv
// gray_to_bin: combinational Gray-to-binary conversion of a synchronized pointer
module gray_to_bin
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_ADDR_WIDTH + 1
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  assign bin = WIDTH'(gray2bin(MAX_WIDTH'(gray)));
endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-domain pointer, empty/almost_empty, level and underflow control of the async FIFO
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                  clk_rcv,
  input  logic                  reset_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  underflow
);
  localparam int PW = ADDR_WIDTH + 1;
  logic [PW-1:0] rbin, rbin_next, rgray_next, wbin_sync, level_next;
  logic rd_fire;
  gray_to_bin #(.WIDTH(PW)) u_gray_to_bin (.gray(wptr_gray_sync), .bin(wbin_sync));
  always_comb begin
    rd_fire = rd_en & ~empty;
    rbin_next = rbin + PW'(rd_fire);
    rgray_next = PW'(bin2gray(MAX_WIDTH'(rbin_next)));
    level_next = wbin_sync - rbin_next;
  end
  // empty compares against the post-read pointer so a read and a new write in one cycle net out
  always_ff @(posedge clk_rcv or negedge reset_n)
    if (!reset_n) begin
      rbin <= '0;
      rptr_gray <= '0;
      empty <= 1'b1;
      almost_empty <= 1'b1;
      rd_level <= '0;
      underflow <= 1'b0;
    end else begin
      rbin <= rbin_next;
      rptr_gray <= rgray_next;
      empty <= rgray_next == wptr_gray_sync;
      almost_empty <= level_next <= PW'(ALMOST_EMPTY_THRESH);
      rd_level <= level_next;
      underflow <= underflow | (rd_en & empty);
    end
  assign rd_addr = rbin[ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed and randomized checks of fifo_rd_ctrl against a read/write-count model
module tb_fifo_rd_ctrl;
  localparam int AW = 4;
  localparam int PW = 5;
  localparam int TH = 2;
  logic clk_rcv = 1'b0;
  logic reset_n = 1'b0;
  logic rd_en = 1'b0;
  logic [PW-1:0] wptr_gray_sync = '0;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rptr_gray, rd_level;
  logic empty, almost_empty, underflow;
  int checks = 0;
  int errors = 0;
  int m_w = 0;
  int m_r = 0;
  bit m_empty = 1'b1;
  bit m_uf = 1'b0;
  always #5 clk_rcv = ~clk_rcv;
  fifo_rd_ctrl #(.ADDR_WIDTH(AW), .ALMOST_EMPTY_THRESH(TH)) dut (
    .clk_rcv(clk_rcv), .reset_n(reset_n), .rd_en(rd_en), .wptr_gray_sync(wptr_gray_sync),
    .rd_addr(rd_addr), .rptr_gray(rptr_gray), .empty(empty), .almost_empty(almost_empty),
    .rd_level(rd_level), .underflow(underflow)
  );
  function automatic logic [PW-1:0] gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction
  function automatic int lvl();
    return (m_w - m_r + 32) % 32;
  endfunction
  task automatic set_w(input int w);
    m_w = w % 32;
    wptr_gray_sync = gray(m_w);
  endtask
  // advance one clock; the model counts reads and writes as plain integers mod 32
  task automatic tick();
    bit fire;
    @(posedge clk_rcv);
    fire = rd_en && !m_empty;
    m_uf = m_uf | (rd_en && m_empty);
    m_r = (m_r + int'(fire)) % 32;
    m_empty = (m_w == m_r);
    #1;
  endtask
  task automatic apply_reset();
    reset_n = 1'b0;
    rd_en = 1'b0;
    set_w(0);
    m_r = 0;
    m_empty = 1'b1;
    m_uf = 1'b0;
    repeat (2) @(posedge clk_rcv);
    #1 reset_n = 1'b1;
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) begin
      rd_en = 1'($urandom);
      wptr_gray_sync = PW'($urandom);
      @(posedge clk_rcv);
      #1;
      checks++;
      if ({rd_addr, rptr_gray, empty, almost_empty, rd_level, underflow} !== {4'h0, 5'h0, 1'b1, 1'b1, 5'h0, 1'b0}) begin
        errors++;
        $display("FAIL reset: addr=%0d gray=%b empty=%b ae=%b lvl=%0d uf=%b, want 0 00000 1 1 0 0",
                 rd_addr, rptr_gray, empty, almost_empty, rd_level, underflow);
      end
    end
    apply_reset();
  endtask
  task automatic test_single();
    set_w(1);
    tick();
    checks++;
    if ({empty, rd_level, almost_empty} !== {1'b0, 5'd1, 1'b1}) begin
      errors++;
      $display("FAIL single_fill: empty=%b lvl=%0d ae=%b, want 0 1 1", empty, rd_level, almost_empty);
    end
    rd_en = 1'b1;
    checks++;
    if (rd_addr !== 4'd0) begin
      errors++;
      $display("FAIL single_addr0: addr=%0d want 0", rd_addr);
    end
    tick();
    rd_en = 1'b0;
    checks++;
    if ({rd_addr, rptr_gray, empty, rd_level} !== {4'd1, 5'b00001, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL single_read: addr=%0d gray=%b empty=%b lvl=%0d, want 1 00001 1 0", rd_addr, rptr_gray, empty, rd_level);
    end
  endtask
  task automatic test_wrap();
    apply_reset();
    set_w(16);
    tick();
    checks++;
    if ({rd_level, empty, almost_empty} !== {5'd16, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wrap_full: lvl=%0d empty=%b ae=%b, want 16 0 0", rd_level, empty, almost_empty);
    end
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_addr !== AW'(i)) begin
        errors++;
        $display("FAIL wrap_addr: step %0d addr=%0d want %0d", i, rd_addr, i);
      end
      tick();
      checks++;
      if (rd_level !== PW'(15 - i) || almost_empty !== (15 - i <= TH)) begin
        errors++;
        $display("FAIL wrap_level: step %0d lvl=%0d ae=%b want %0d %b", i, rd_level, almost_empty, 15 - i, 15 - i <= TH);
      end
    end
    rd_en = 1'b0;
    checks++;
    if ({rd_addr, rptr_gray, empty} !== {4'd0, 5'b11000, 1'b1}) begin
      errors++;
      $display("FAIL wrap_end: addr=%0d gray=%b empty=%b, want 0 11000 1", rd_addr, rptr_gray, empty);
    end
  endtask
  task automatic test_underflow();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    repeat (3) tick();
    checks++;
    if ({underflow, rptr_gray, rd_addr} !== {1'b1, 5'b11000, 4'd0}) begin
      errors++;
      $display("FAIL underflow: uf=%b gray=%b addr=%0d, want 1 11000 0", underflow, rptr_gray, rd_addr);
    end
    apply_reset();
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear: uf=%b want 0", underflow);
    end
  endtask
  task automatic test_simultaneous();
    set_w(1);
    tick();
    rd_en = 1'b1;
    set_w(2);
    tick();
    rd_en = 1'b0;
    checks++;
    if ({empty, rd_level, rd_addr} !== {1'b0, 5'd1, 4'd1}) begin
      errors++;
      $display("FAIL simultaneous: empty=%b lvl=%0d addr=%0d, want 0 1 1", empty, rd_level, rd_addr);
    end
  endtask
  task automatic test_reset_mid();
    apply_reset();
    set_w(10);
    tick();
    rd_en = 1'b1;
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({rd_addr, rptr_gray, empty, almost_empty, rd_level, underflow} !== {4'h0, 5'h0, 1'b1, 1'b1, 5'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async: addr=%0d gray=%b empty=%b ae=%b lvl=%0d uf=%b, want 0 00000 1 1 0 0",
               rd_addr, rptr_gray, empty, almost_empty, rd_level, underflow);
    end
    apply_reset();
  endtask
  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 500; n++) begin
      rd_en = 1'($urandom_range(0, 1));
      if (lvl() < 16 && $urandom_range(0, 2) != 0) set_w(m_w + 1);
      tick();
      checks++;
      if ({rd_addr, rptr_gray, empty, almost_empty, rd_level, underflow} !==
          {AW'(m_r), gray(m_r), m_empty, lvl() <= TH, PW'(lvl()), m_uf}) begin
        errors++;
        $display("FAIL random: cyc %0d addr=%0d gray=%b empty=%b ae=%b lvl=%0d uf=%b, want %0d %b %b %b %0d %b",
                 n, rd_addr, rptr_gray, empty, almost_empty, rd_level, underflow,
                 m_r % 16, gray(m_r), m_empty, lvl() <= TH, lvl(), m_uf);
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_underflow();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side pointer and empty-flag controller of the asynchronous FIFO, in the read clock domain.
- Consumes the write pointer, Gray-coded and already passed through the 2-stage synchronizer.
- Produces the RAM read address and the Gray read pointer; the Gray read pointer goes to the write-domain synchronizer.
- Generates empty, almost_empty, fill level and sticky underflow status for the read-side consumer.

Parameters:
ADDR_WIDTH, 4, RAM address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
ALMOST_EMPTY_THRESH, 2, almost_empty asserts when the registered level is <= this value (range 0..2**ADDR_WIDTH).

Ports:
clk_rcv  input  1  read-domain clock; all logic is posedge.
reset_n  input  1  asynchronous, active-low reset.
rd_en  input  1  read request from the consumer.
wptr_gray_sync  input  ADDR_WIDTH+1  synchronized Gray write pointer.
rd_addr  output  ADDR_WIDTH  RAM read address, equal to rbin[ADDR_WIDTH-1:0].
rptr_gray  output  ADDR_WIDTH+1  registered Gray read pointer, sent to the write-domain synchronizer.
empty  output  1  FIFO empty (registered, pessimistic).
almost_empty  output  1  level <= ALMOST_EMPTY_THRESH.
rd_level  output  ADDR_WIDTH+1  entries available, range 0..2**ADDR_WIDTH.
underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset state (asynchronous on reset_n low, released synchronously on clk_rcv), applied to every register:
  - rbin = 0, rptr_gray = 0, rd_addr = 0
  - empty = 1, almost_empty = 1, rd_level = 0, underflow = 0
- Read qualification: rd_fire = rd_en & ~empty.
  - Registered empty is the sole qualifier; a read while empty is ignored.
- Pointer update, all arithmetic modulo 2**(ADDR_WIDTH+1):
  - rbin_next = rbin + rd_fire
  - rgray_next = rbin_next ^ (rbin_next >> 1)
  - rbin and rptr_gray register their _next values every cycle.
  - Both pointers wrap naturally, e.g. 15 -> 16 -> … -> 31 -> 0 for ADDR_WIDTH=4.
  - rptr_gray is driven straight from a flop; no combinational path to the output, so it is safe to cross domains.
- Empty:
  - empty <= (rgray_next == wptr_gray_sync), registered.
  - Empty deasserts one clk_rcv cycle after wptr_gray_sync changes; end-to-end write-to-visible latency is 3 read clocks after the write pointer register updates.
  - Empty may stay asserted while data is present. Empty is never deasserted while the FIFO is truly empty.
- Level:
  - wbin_sync = Gray-to-binary of wptr_gray_sync, combinational.
  - rd_level <= wbin_sync - rbin_next, registered.
  - almost_empty <= (wbin_sync - rbin_next) <= ALMOST_EMPTY_THRESH.
  - A level of exactly 2**ADDR_WIDTH (full) is represented correctly through the extra MSB.
- Read and pointer update in the same cycle: both terms are used in the same next-state computation.
  - Example: level 1, a read, and a new write arriving together -> level stays 1, empty stays 0.
- Underflow:
  - underflow <= underflow | (rd_en & empty).
  - It clears only on reset.
  - Pointers do not move on an underflowing read.
- Reset mid-operation:
  - All state returns to the reset values immediately.
  - The write domain must be reset concurrently; no resynchronization handshake exists in this block.
- rd_addr is valid in the cycle rd_fire is high.
  - The RAM is synchronous-read: data appears the cycle after rd_fire. Registering that data is the consumer's responsibility.

Decomposition:
- Package fifo_pkg holds:
  - the bin2gray and gray2bin functions, parameterized by width through automatic functions with a fixed maximum width;
  - the default ADDR_WIDTH constant.
- This block and the write-side controller share the package.
- Sub-module gray_to_bin (combinational, WIDTH parameter) converts wptr_gray_sync.
  - It is reused by the write-side controller for the synchronized read pointer.

Test Plan:
1. Reset: hold reset_n=0 with random rd_en and wptr_gray_sync -> rd_addr=0, rptr_gray=0, empty=1, almost_empty=1, rd_level=0, underflow=0.
2. Single entry: wptr_gray_sync 0->1 -> next cycle empty=0, rd_level=1, almost_empty=1. Then rd_en=1 for one cycle -> rd_addr 0->1, rptr_gray 0->1, empty=1, rd_level=0.
3. Wrap: ADDR_WIDTH=4, write pointer set to 16 (Gray 5'b11000), then 16 consecutive reads -> rd_addr steps 0..15 then back to 0, rptr_gray=5'b11000, empty=1 after the last read. During the test, rd_level peaks at 16 and almost_empty asserts once level <= 2.
4. Underflow: empty=1, pulse rd_en -> underflow=1 and stays 1, rptr_gray unchanged. Apply reset -> underflow=0.
5. Simultaneous events: level 1, rd_en=1 in the same cycle that wptr_gray_sync advances by one -> empty stays 0, rd_level stays 1, rd_addr increments.
6. Reset mid-burst: level 10 with continuous reads, assert reset_n=0 asynchronously mid-cycle -> outputs return to reset values without waiting for a clock edge.
